// File: rtl/light_status_display.sv
// ---------------------------------------------------------------------------
// light_status_display
// Consumer of the traffic-light state controller. On every 1 Hz edge it
// samples the countdown and the three lamp signals, then:
//   - drives a countdown digit and a phase-letter digit (G/Y/r), active-low;
//   - counts completed G->Y->R cycles in two BCD digits (wraps 99 -> 00);
//   - runs a sticky sequence monitor for illegal lamp patterns, dropouts
//     and out-of-order phases (first fault code since the last clear wins).
//
// Ports
//   iClk1Hz     in   1   1 Hz clock, posedge
//   iRst_n      in   1   asynchronous active-low reset
//   iCounter    in   4   countdown value from the controller
//   iGreen      in   1   green lamp
//   iYellow     in   1   yellow lamp
//   iRed        in   1   red lamp
//   iClrFault   in   1   synchronous clear of fault flag/code
//   oSegCnt     out  7   countdown digit, active-low {g,f,e,d,c,b,a}
//   oSegPhase   out  7   phase letter digit, active-low {g,f,e,d,c,b,a}
//   oCycOnes    out  4   BCD ones of completed cycles
//   oCycTens    out  4   BCD tens of completed cycles
//   oFault      out  1   sticky fault flag
//   oFaultCode  out  2   1 = illegal lamps, 2 = dropout, 3 = out of order
//
// Optional build macro: YELLOW_BLINK_EN
//   When defined, the countdown digit blanks on every second edge while the
//   yellow phase is sampled, so it flashes at 0.5 Hz.
// ---------------------------------------------------------------------------
module light_status_display #(
   parameter logic [6:0] SEG_BLANK    = 7'h7F,
   parameter logic [3:0] CYC_MAX_TENS = 4'd9
) (
   input  logic       iClk1Hz,
   input  logic       iRst_n,
   input  logic [3:0] iCounter,
   input  logic       iGreen,
   input  logic       iYellow,
   input  logic       iRed,
   input  logic       iClrFault,
   output logic [6:0] oSegCnt,
   output logic [6:0] oSegPhase,
   output logic [3:0] oCycOnes,
   output logic [3:0] oCycTens,
   output logic       oFault,
   output logic [1:0] oFaultCode
);

   localparam logic [1:0] FC_ILLEGAL = 2'd1;
   localparam logic [1:0] FC_DROPOUT = 2'd2;
   localparam logic [1:0] FC_ORDER   = 2'd3;

   localparam logic [6:0] LET_G = 7'h42;
   localparam logic [6:0] LET_Y = 7'h11;
   localparam logic [6:0] LET_R = 7'h2F;

   typedef enum logic [1:0] {S_IDLE, S_G, S_Y, S_R} state_t;
   typedef enum logic [2:0] {PH_NONE, PH_G, PH_Y, PH_R, PH_ILLEGAL} phase_t;

   state_t     state;
   state_t     stateNext;
   phase_t     phase;
   state_t     phaseState;
   state_t     succState;
   logic       faultDet;
   logic [1:0] faultCodeDet;
   logic       cycInc;

   logic [6:0] digitCode;
   logic [6:0] segCntNext;
   logic [6:0] segPhaseNext;
   logic [3:0] cycOnesNext;
   logic [3:0] cycTensNext;
   logic       faultNext;
   logic [1:0] faultCodeNext;

`ifdef YELLOW_BLINK_EN
   logic       blinkToggle;
   logic       blinkToggleNext;
`endif

   // Lamp decode: exactly one lamp names a phase, none or several do not.
   always_comb begin
      phase = PH_NONE;
      case ({iGreen, iYellow, iRed})
         3'b000:  phase = PH_NONE;
         3'b100:  phase = PH_G;
         3'b010:  phase = PH_Y;
         3'b001:  phase = PH_R;
         default: phase = PH_ILLEGAL;
      endcase
   end

   // Monitor state that the sampled phase corresponds to, and the legal successor of the current state.
   always_comb begin
      phaseState = S_IDLE;
      case (phase)
         PH_G:    phaseState = S_G;
         PH_Y:    phaseState = S_Y;
         PH_R:    phaseState = S_R;
         default: phaseState = S_IDLE;
      endcase
      succState = S_IDLE;
      case (state)
         S_G:     succState = S_Y;
         S_Y:     succState = S_R;
         S_R:     succState = S_G;
         default: succState = S_IDLE;
      endcase
   end

   // Monitor state register.
   always_ff @(posedge iClk1Hz or negedge iRst_n) begin
      if (!iRst_n) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Monitor next state plus fault and cycle-completion detection.
   always_comb begin
      stateNext    = state;
      faultDet     = 1'b0;
      faultCodeDet = 2'd0;
      cycInc       = 1'b0;
      case (phase)
         PH_NONE: begin
            if (state != S_IDLE) begin
               faultDet     = 1'b1;
               faultCodeDet = FC_DROPOUT;
            end
         end
         PH_ILLEGAL: begin
            faultDet     = 1'b1;
            faultCodeDet = FC_ILLEGAL;
         end
         default: begin
            if (state == S_IDLE || phaseState == state) begin
               stateNext = phaseState;
            end else if (phaseState == succState) begin
               stateNext = phaseState;
               cycInc    = (state == S_R);
            end else begin
               // Resync to what the controller is actually showing.
               stateNext    = phaseState;
               faultDet     = 1'b1;
               faultCodeDet = FC_ORDER;
            end
         end
      endcase
   end

   // Countdown value to active-low seven-segment code; out-of-range shows 'E'.
   always_comb begin
      digitCode = 7'h06;
      case (iCounter)
         4'd0:    digitCode = 7'h40;
         4'd1:    digitCode = 7'h79;
         4'd2:    digitCode = 7'h24;
         4'd3:    digitCode = 7'h30;
         4'd4:    digitCode = 7'h19;
         4'd5:    digitCode = 7'h12;
         4'd6:    digitCode = 7'h02;
         4'd7:    digitCode = 7'h78;
         4'd8:    digitCode = 7'h00;
         4'd9:    digitCode = 7'h10;
         default: digitCode = 7'h06;
      endcase
   end

   // Next values of all registered outputs.
   always_comb begin
      segCntNext    = SEG_BLANK;
      segPhaseNext  = SEG_BLANK;
      cycOnesNext   = oCycOnes;
      cycTensNext   = oCycTens;
      faultNext     = oFault;
      faultCodeNext = oFaultCode;
`ifdef YELLOW_BLINK_EN
      blinkToggleNext = 1'b0;
`endif

      case (phase)
         PH_G: begin
            segCntNext   = digitCode;
            segPhaseNext = LET_G;
         end
         PH_Y: begin
            segCntNext   = digitCode;
            segPhaseNext = LET_Y;
`ifdef YELLOW_BLINK_EN
            // Blank on alternate edges; the first yellow edge always shows the digit.
            if (blinkToggle) begin
               segCntNext = SEG_BLANK;
            end
            blinkToggleNext = ~blinkToggle;
`endif
         end
         PH_R: begin
            segCntNext   = digitCode;
            segPhaseNext = LET_R;
         end
         default: begin
            segCntNext   = SEG_BLANK;
            segPhaseNext = SEG_BLANK;
         end
      endcase

      // BCD cycle count, wrapping at CYC_MAX_TENS:9.
      if (cycInc) begin
         if (oCycOnes == 4'd9) begin
            cycOnesNext = 4'd0;
            if (oCycTens == CYC_MAX_TENS) begin
               cycTensNext = 4'd0;
            end else begin
               cycTensNext = oCycTens + 4'd1;
            end
         end else begin
            cycOnesNext = oCycOnes + 4'd1;
         end
      end

      // A fault on the clear edge beats the clear; otherwise first fault wins.
      if (faultDet) begin
         faultNext = 1'b1;
         if (!oFault || iClrFault) begin
            faultCodeNext = faultCodeDet;
         end
      end else if (iClrFault) begin
         faultNext     = 1'b0;
         faultCodeNext = 2'd0;
      end
   end

   // Output registers.
   always_ff @(posedge iClk1Hz or negedge iRst_n) begin
      if (!iRst_n) begin
         oSegCnt    <= SEG_BLANK;
         oSegPhase  <= SEG_BLANK;
         oCycOnes   <= 4'd0;
         oCycTens   <= 4'd0;
         oFault     <= 1'b0;
         oFaultCode <= 2'd0;
      end else begin
         oSegCnt    <= segCntNext;
         oSegPhase  <= segPhaseNext;
         oCycOnes   <= cycOnesNext;
         oCycTens   <= cycTensNext;
         oFault     <= faultNext;
         oFaultCode <= faultCodeNext;
      end
   end

`ifdef YELLOW_BLINK_EN
   // Yellow flash phase bit.
   always_ff @(posedge iClk1Hz or negedge iRst_n) begin
      if (!iRst_n) begin
         blinkToggle <= 1'b0;
      end else begin
         blinkToggle <= blinkToggleNext;
      end
   end
`endif

endmodule
